// File: rtl/hilo_mdu_ctrl_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
// Op bit positions, the sequencer state type and the packed EX->MDU request.
package mdu_pkg;

    localparam int unsigned MDU_W     = 32;
    localparam int unsigned MDU_OP_WD = 6;

    localparam int unsigned MDU_DIV   = 5;
    localparam int unsigned MDU_DIVU  = 4;
    localparam int unsigned MDU_MULT  = 3;
    localparam int unsigned MDU_MULTU = 2;
    localparam int unsigned MDU_MTHI  = 1;
    localparam int unsigned MDU_MTLO  = 0;

    localparam int unsigned MDU_STEPS = 32;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    typedef struct packed {
        logic                 valid;
        logic [MDU_OP_WD-1:0] op;
        logic [MDU_W-1:0]     a;
        logic [MDU_W-1:0]     b;
    } mdu_req_t;

    localparam int unsigned MDU_BUS_WD = $bits(mdu_req_t);

    // Magnitude of a value that is two's-complement only when sgn is set.
    function automatic logic [MDU_W-1:0] mdu_abs(input logic [MDU_W-1:0] v, input logic sgn);
        return (sgn && v[MDU_W-1]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_mdu_ctrl_if.sv
// EX <-> MDU signal bundle; master is the EX/stall-controller side.
interface hilo_mdu_ctrl_if import mdu_pkg::*; #(parameter int unsigned W = 32) ();

    logic                 op_valid;
    logic [MDU_OP_WD-1:0] mdu_op;
    logic [W-1:0]         src_a;
    logic [W-1:0]         src_b;
    logic                 flush;
    logic                 ex_stall;
    logic                 stallreq_for_mdu;
    logic                 busy;
    logic [W-1:0]         hi_rdata;
    logic [W-1:0]         lo_rdata;

    modport master (
        output op_valid, mdu_op, src_a, src_b, flush, ex_stall,
        input  stallreq_for_mdu, busy, hi_rdata, lo_rdata
    );

    modport slave (
        input  op_valid, mdu_op, src_a, src_b, flush, ex_stall,
        output stallreq_for_mdu, busy, hi_rdata, lo_rdata
    );

endinterface

// File: rtl/hilo_mdu_ctrl_iter_core.sv
// 64-bit shift-add multiply / restoring divide datapath, one step per cycle.
// result is the working register after the current step, so the caller can commit on the last step edge.
module mdu_iter_core import mdu_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic [63:0] result
);

    logic [63:0] acc;
    logic [31:0] m;
    logic [63:0] acc_step;
    logic [32:0] sum;
    logic        ge;
    logic [31:0] diff;

    always_comb begin
        sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
        // Shifted partial remainder is acc[63:31]; its low 32 bits suffice once the trial succeeds.
        ge       = acc[63:31] >= {1'b0, m};
        diff     = acc[62:31] - m;
        acc_step = acc;
        if (is_div) begin
            acc_step = ge ? {diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
        end else begin
            acc_step = {sum, acc[31:1]};
        end
    end

    assign result = acc_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            m   <= '0;
        end else if (load) begin
            acc <= is_div ? {32'd0, op_a} : {32'd0, op_b};
            m   <= is_div ? op_b : op_a;
        end else if (step) begin
            acc <= acc_step;
        end
    end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO owner and multi-cycle mult/div sequencer beside EX.
// Raises the EX stall request from accept until the result is committed.
module hilo_mdu_ctrl import mdu_pkg::*; #(
    parameter int unsigned W = 32
) (
    input  logic            clk,
    input  logic            rst,
    hilo_mdu_ctrl_if.slave  bus
);

    logic [MDU_BUS_WD-1:0] req_bits;
    mdu_req_t              req;

    mdu_state_t  state;
    logic [4:0]  cnt;
    logic [W-1:0] hi, lo;
    logic        neg_q, neg_r, is_div_r;

    logic         is_md, sgn, start_div, start;
    logic [W-1:0] a_abs, b_abs;
    logic [63:0]  res, prod;
    logic [W-1:0] quo, rem, hi_fix, lo_fix;

    assign req_bits = {bus.op_valid, bus.mdu_op, bus.src_a, bus.src_b};
    assign req      = mdu_req_t'(req_bits);

    assign is_md     = req.op[MDU_DIV] | req.op[MDU_DIVU] | req.op[MDU_MULT] | req.op[MDU_MULTU];
    assign sgn       = req.op[MDU_DIV] | req.op[MDU_MULT];
    assign start_div = req.op[MDU_DIV] | req.op[MDU_DIVU];
    assign start     = (state == MDU_IDLE) & req.valid & is_md & ~bus.flush;
    assign a_abs     = mdu_abs(req.a, sgn);
    assign b_abs     = mdu_abs(req.b, sgn);

    mdu_iter_core u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (start),
        .step   (state == MDU_BUSY),
        .is_div ((state == MDU_IDLE) ? start_div : is_div_r),
        .op_a   (a_abs),
        .op_b   (b_abs),
        .result (res)
    );

    always_comb begin
        prod   = neg_q ? (~res + 64'd1) : res;
        quo    = neg_q ? (~res[31:0] + 32'd1) : res[31:0];
        rem    = neg_r ? (~res[63:32] + 32'd1) : res[63:32];
        hi_fix = is_div_r ? rem : prod[63:32];
        lo_fix = is_div_r ? quo : prod[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MDU_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_div_r <= 1'b0;
        end else begin
            unique case (state)
                MDU_IDLE: begin
                    if (req.valid && !bus.flush) begin
                        if (is_md) begin
                            state    <= MDU_BUSY;
                            cnt      <= '0;
                            neg_q    <= sgn & (req.a[W-1] ^ req.b[W-1]);
                            neg_r    <= sgn & req.a[W-1];
                            is_div_r <= start_div;
                        end else if (req.op[MDU_MTHI]) begin
                            hi <= req.a;
                        end else if (req.op[MDU_MTLO]) begin
                            lo <= req.a;
                        end
                    end
                end
                MDU_BUSY: begin
                    if (bus.flush) begin
                        state <= MDU_IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'(MDU_STEPS - 1)) begin
                            hi    <= hi_fix;
                            lo    <= lo_fix;
                            state <= MDU_DONE;
                        end
                    end
                end
                MDU_DONE: begin
                    if (bus.flush || !bus.ex_stall) state <= MDU_IDLE;
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

    assign bus.stallreq_for_mdu = ~bus.flush &
                                  (((state == MDU_IDLE) & req.valid & is_md) | (state == MDU_BUSY));
    assign bus.busy     = (state == MDU_BUSY);
    assign bus.hi_rdata = hi;
    assign bus.lo_rdata = lo;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Directed bench for hilo_mdu_ctrl: expected HI/LO pairs queued at issue, compared at DONE.
module tb_hilo_mdu_ctrl;
    import mdu_pkg::*;

    localparam logic [5:0] OP_DIV   = 6'b100000;
    localparam logic [5:0] OP_DIVU  = 6'b010000;
    localparam logic [5:0] OP_MULT  = 6'b001000;
    localparam logic [5:0] OP_MULTU = 6'b000100;
    localparam logic [5:0] OP_MTHI  = 6'b000010;
    localparam logic [5:0] OP_MTLO  = 6'b000001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_mdu_ctrl_if #(.W(32)) bus ();

    hilo_mdu_ctrl #(.W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [63:0] sb[$];

    // Reference result {HI, LO} from the arithmetic definition, with the
    // documented divide-by-zero behaviour (quotient all ones, remainder |a|).
    function automatic logic [63:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [31:0] ua, ub, q, r;
        logic [63:0] p;
        s  = op[MDU_DIV] | op[MDU_MULT];
        ua = (s && a[31]) ? -a : a;
        ub = (s && b[31]) ? -b : b;
        if (op[MDU_MULT] || op[MDU_MULTU]) begin
            p = {32'd0, ua} * {32'd0, ub};
            if (s && (a[31] ^ b[31])) p = -p;
            return p;
        end
        if (ub == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (s && (a[31] ^ b[31])) q = -q;
        if (s && a[31]) r = -r;
        return {r, q};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.op_valid = 1'b0;
        bus.mdu_op   = '0;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.flush    = 1'b0;
        bus.ex_stall = 1'b0;
    endtask

    // Issues one op at the next negedge and follows it through DONE. The
    // instruction stays in EX while stalled; `hold` DONE cycles see ex_stall.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        int          n;
        logic [63:0] exp;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.mdu_op   = op;
        bus.src_a    = a;
        bus.src_b    = b;
        sb.push_back(model(op, a, b));
        n = 0;
        #1;
        while (bus.stallreq_for_mdu && n < 100) begin
            n++;
            if (n == 2) check({tag, "_busy_mid"}, 64'(bus.busy), 64'd1);
            @(negedge clk);
            #1;
        end
        check({tag, "_stall_cycles"}, 64'(n), 64'd33);
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd0);
        exp = sb.pop_front();
        check({tag, "_hi"}, 64'(bus.hi_rdata), 64'(exp[63:32]));
        check({tag, "_lo"}, 64'(bus.lo_rdata), 64'(exp[31:0]));
        for (int i = 0; i < hold; i++) begin
            bus.ex_stall = 1'b1;
            check({tag, "_done_hold_nostall"}, 64'(bus.stallreq_for_mdu), 64'd0);
            check({tag, "_done_hold_busy"}, 64'(bus.busy), 64'd0);
            @(negedge clk);
            #1;
        end
        bus.ex_stall = 1'b0;
        check({tag, "_done_last_nostall"}, 64'(bus.stallreq_for_mdu), 64'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        drive_idle();
        #1;
        check("rst_hi", 64'(bus.hi_rdata), 64'd0);
        check("rst_lo", 64'(bus.lo_rdata), 64'd0);
        check("rst_stall", 64'(bus.stallreq_for_mdu), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("mult_7_m3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 0);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("divu_7_0", OP_DIVU, 32'd7, 32'd0, 0);
        run_op("div_m7_0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 0);
        run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        for (int i = 0; i < 6; i++) begin
            logic [5:0]  op;
            logic [31:0] a, b;
            case ($urandom_range(0, 3))
                0:       op = OP_DIV;
                1:       op = OP_DIVU;
                2:       op = OP_MULT;
                default: op = OP_MULTU;
            endcase
            a = $urandom;
            b = $urandom;
            if (i % 2 == 1) b = b >> 26;
            run_op($sformatf("rand%0d", i), op, a, b, 0);
        end

        // mtlo then mthi back to back, no stall, visible next cycle
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.mdu_op   = OP_MTLO;
        bus.src_a    = 32'h1234_5678;
        #1;
        check("mtlo_nostall", 64'(bus.stallreq_for_mdu), 64'd0);
        @(negedge clk);
        bus.mdu_op = OP_MTHI;
        bus.src_a  = 32'hABCD_0000;
        #1;
        check("mthi_nostall", 64'(bus.stallreq_for_mdu), 64'd0);
        check("mtlo_lo", 64'(bus.lo_rdata), 64'h1234_5678);
        @(negedge clk);
        drive_idle();
        #1;
        check("mthi_hi", 64'(bus.hi_rdata), 64'hABCD_0000);
        check("mthi_lo_kept", 64'(bus.lo_rdata), 64'h1234_5678);
        check("mt_busy", 64'(bus.busy), 64'd0);

        // flush in IDLE blocks both mthi and a start
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.mdu_op   = OP_MTHI;
        bus.src_a    = 32'h5555_AAAA;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.mdu_op = OP_MULT;
        #1;
        check("idle_flush_hi", 64'(bus.hi_rdata), 64'hABCD_0000);
        check("idle_flush_stall", 64'(bus.stallreq_for_mdu), 64'd0);
        @(negedge clk);
        drive_idle();
        #1;
        check("idle_flush_nobusy", 64'(bus.busy), 64'd0);

        // multu flushed at BUSY step 10
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.mdu_op   = OP_MULTU;
        bus.src_a    = 32'h0001_0001;
        bus.src_b    = 32'h0000_0300;
        #1;
        check("flush_accept_stall", 64'(bus.stallreq_for_mdu), 64'd1);
        for (int i = 0; i < 11; i++) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("flush_busy_before", 64'(bus.busy), 64'd1);
        check("flush_stall_low", 64'(bus.stallreq_for_mdu), 64'd0);
        @(negedge clk);
        drive_idle();
        #1;
        check("flush_idle", 64'(bus.busy), 64'd0);
        check("flush_hi_kept", 64'(bus.hi_rdata), 64'hABCD_0000);
        check("flush_lo_kept", 64'(bus.lo_rdata), 64'h1234_5678);
        for (int i = 0; i < 25; i++) @(negedge clk);
        #1;
        check("flush_hi_late", 64'(bus.hi_rdata), 64'hABCD_0000);
        check("flush_lo_late", 64'(bus.lo_rdata), 64'h1234_5678);

        // divu 100/7 with 3 cycles of ex_stall in DONE, then a back-to-back op
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 3);
        check("divu_100_7_hi_const", 64'(bus.hi_rdata), 64'd2);
        check("divu_100_7_lo_const", 64'(bus.lo_rdata), 64'd14);
        run_op("b2b_multu", OP_MULTU, 32'd6, 32'd9, 0);

        // asynchronous reset in the middle of BUSY
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.mdu_op   = OP_MULT;
        bus.src_a    = 32'd11;
        bus.src_b    = 32'd13;
        for (int i = 0; i < 5; i++) @(negedge clk);
        #1;
        check("prerst_busy", 64'(bus.busy), 64'd1);
        #1;
        rst = 1'b1;
        drive_idle();
        #1;
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_stall", 64'(bus.stallreq_for_mdu), 64'd0);
        check("arst_hi", 64'(bus.hi_rdata), 64'd0);
        check("arst_lo", 64'(bus.lo_rdata), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("mult_3_5", OP_MULT, 32'd3, 32'd5, 0);

        @(negedge clk);
        drive_idle();
        n = sb.size();
        check("scoreboard_empty", 64'(n), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
